// File: rtl/patgen_pkg.sv
// Shared types and helpers for the constant-weight pattern generator.
// Holds the FSM state encoding, default sizes and the first/last word helpers.
package patgen_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned CW_DEF    = 4;
    localparam int unsigned IDXW_DEF  = 7;

    typedef enum logic {
        IDLE,
        EMIT
    } state_e;

    // Smallest word of weight k: the k LSBs set. Sized for the widest legal WIDTH plus one.
    function automatic logic [16:0] first_pat(input int unsigned k);
        first_pat = (17'd1 << k) - 17'd1;
    endfunction

    // Largest word of weight k within a width-bit field: the k MSBs set.
    function automatic logic [16:0] last_pat(input int unsigned k, input int unsigned width);
        last_pat = first_pat(k) << (width - k);
    endfunction

endpackage

// File: rtl/gosper_next.sv
// Combinational successor of a constant-weight word (Gosper's hack).
// wrap flags that x has no successor of the same weight within WIDTH bits.
module gosper_next #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] nxt,
    output logic             wrap
);

    localparam int unsigned TZW = $clog2(WIDTH + 1);

    logic [WIDTH:0]   xe;
    logic [WIDTH:0]   c;
    logic [WIDTH:0]   r;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   nxt_full;
    logic [TZW-1:0]   tz;

    always_comb begin
        xe = {1'b0, x};
        c  = xe & (~xe + 1'b1);
        r  = xe + c;

        // Descending scan so the lowest set bit of c wins; replaces the divide by c.
        tz = '0;
        for (int unsigned i = WIDTH + 1; i > 0; i--) begin
            if (c[i-1]) begin
                tz = TZW'(i - 1);
            end
        end

        shifted  = ((r ^ xe) >> 2) >> tz;
        nxt_full = r | shifted;
        nxt      = nxt_full[WIDTH-1:0];
        wrap     = nxt_full[WIDTH];
    end

endmodule

// File: rtl/ones_pattern_gen.sv
// Enumerates every WIDTH-bit word with exactly k ones, ascending, over a valid/ready stream.
// Optional PATGEN_SELFCHECK_EN adds a sticky chk_err output checking weight and ordering.
module ones_pattern_gen
    import patgen_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CW    = CW_DEF,
    parameter int unsigned IDXW  = IDXW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CW-1:0]    k,
    input  logic             abort,
    output logic             busy,
    output logic             bad_k,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last
`ifdef PATGEN_SELFCHECK_EN
    ,
    output logic             chk_err
`endif
);

    localparam int unsigned PADW = 17 - WIDTH;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              last_q, last_d;
    logic [CW-1:0]     k_q, k_d;
    logic              bad_q, bad_d;

    logic [WIDTH-1:0]  gos_next;
    logic              gos_wrap;
    logic [16:0]       first_w;
    logic [16:0]       last_start_w;
    logic [16:0]       last_cur_w;
    logic              k_ok;

    gosper_next #(
        .WIDTH(WIDTH)
    ) u_gosper (
        .x    (data_q),
        .nxt  (gos_next),
        .wrap (gos_wrap)
    );

    always_comb begin
        first_w      = first_pat(32'(k));
        last_start_w = last_pat(32'(k), WIDTH);
        last_cur_w   = last_pat(32'(k_q), WIDTH);
        k_ok         = (k <= CW'(WIDTH));
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        k_d     = k_q;
        bad_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (k_ok) begin
                        state_d = EMIT;
                        data_d  = first_w[WIDTH-1:0];
                        idx_d   = '0;
                        k_d     = k;
                        last_d  = (first_w == last_start_w);
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                // Abort outranks a same-cycle handshake: the presented word is dropped.
                if (abort || (out_ready && last_q)) begin
                    state_d = IDLE;
                    data_d  = '0;
                    idx_d   = '0;
                    last_d  = 1'b0;
                end else if (out_ready) begin
                    data_d = gos_next;
                    idx_d  = idx_q + 1'b1;
                    last_d = ({{PADW{1'b0}}, gos_next} == last_cur_w) || gos_wrap;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            k_q     <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            k_q     <= k_d;
            bad_q   <= bad_d;
        end
    end

    assign busy      = (state_q == EMIT);
    assign out_valid = (state_q == EMIT);
    assign out_data  = data_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign bad_k     = bad_q;

`ifdef PATGEN_SELFCHECK_EN
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             have_prev_q, have_prev_d;
    logic             chk_q, chk_d;
    logic [CW-1:0]    pc;
    logic             accept;
    logic             start_acc;

    // Checks the word as seen on the port, so a corrupted output is caught too.
    always_comb begin
        pc = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pc = pc + CW'(out_data[i]);
        end
        accept    = (state_q == EMIT) && out_ready && !abort;
        start_acc = (state_q == IDLE) && start && !abort && k_ok;

        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        chk_d       = chk_q;
        if (start_acc) begin
            chk_d       = 1'b0;
            have_prev_d = 1'b0;
        end else if (accept) begin
            if ((pc != k_q) || (have_prev_q && (out_data <= prev_q))) begin
                chk_d = 1'b1;
            end
            prev_d      = out_data;
            have_prev_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            chk_q       <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            chk_q       <= chk_d;
        end
    end

    assign chk_err = chk_q;
`endif

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Directed bench for ones_pattern_gen (WIDTH=8); expected words come from a brute-force
// ascending popcount search. PATGEN_SELFCHECK_EN enables the chk_err scenario.
module tb_ones_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] k;
    logic       abort;
    logic       busy;
    logic       bad_k;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [6:0] out_idx;
    logic       out_last;
`ifdef PATGEN_SELFCHECK_EN
    logic       chk_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ones_pattern_gen #(
        .WIDTH(8),
        .CW   (4),
        .IDXW (7)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .k         (k),
        .abort     (abort),
        .busy      (busy),
        .bad_k     (bad_k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
`ifdef PATGEN_SELFCHECK_EN
        ,
        .chk_err   (chk_err)
`endif
    );

    // Next larger 8-bit word with kk ones, by exhaustive search.
    function automatic logic [7:0] next_w(input logic [7:0] x, input int kk);
        for (int v = int'(x) + 1; v < 256; v++) begin
            if ($countones(8'(v)) == kk) return 8'(v);
        end
        return 8'h00;
    endfunction

    // Pulses start for one cycle; returns at the negedge after the accepting edge.
    task automatic pulse_start(input logic [3:0] kk);
        start = 1'b1;
        k     = kk;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; k = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, bad_k, out_valid, out_last} !== 4'b0000 || out_data !== 8'h00 || out_idx !== 7'd0) begin
            failures++;
            $display("FAIL reset_state: busy=%b bad_k=%b valid=%b last=%b data=%h idx=%0d, required all zero",
                     busy, bad_k, out_valid, out_last, out_data, out_idx);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_k3();
        logic [7:0] exp, first_seen, second_seen;
        int n = 0;
        bit done = 0;
        out_ready = 1'b1;
        exp = 8'h07; first_seen = '0; second_seen = '0;
        pulse_start(4'd3);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (n == 0) first_seen = out_data;
            if (n == 1) second_seen = out_data;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp || out_idx !== 7'(n)) begin
                failures++;
                $display("FAIL k3_word: valid=%b data=%h idx=%0d, required valid=1 data=%h idx=%0d",
                         out_valid, out_data, out_idx, exp, n);
            end
            checks++;
            if (out_last !== (exp == 8'hE0)) begin
                failures++;
                $display("FAIL k3_last: last=%b at data=%h, required %b", out_last, exp, exp == 8'hE0);
            end
            if (exp == 8'hE0) done = 1;
            else begin
                exp = next_w(exp, 3);
                n++;
            end
            @(negedge clk);
        end
        checks++;
        if (first_seen !== 8'h07 || second_seen !== 8'h0B) begin
            failures++;
            $display("FAIL k3_first_two: got %h %h, required 07 0B", first_seen, second_seen);
        end
        checks++;
        if (!done || n != 55) begin
            failures++;
            $display("FAIL k3_length: done=%0d last_idx=%0d, required done=1 last_idx=55", done, n);
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL k3_idle_after: busy=%b valid=%b, required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_single_words();
        logic [3:0] kk;
        logic [7:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            kk  = (i == 0) ? 4'd0 : 4'd8;
            exp = (i == 0) ? 8'h00 : 8'hFF;
            pulse_start(kk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp || out_last !== 1'b1 || out_idx !== 7'd0) begin
                failures++;
                $display("FAIL single_k%0d: valid=%b data=%h last=%b idx=%0d, required 1 %h 1 0",
                         kk, out_valid, out_data, out_last, out_idx, exp);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL single_k%0d_end: valid=%b busy=%b, required 0 0", kk, out_valid, busy);
            end
        end
        pulse_start(4'd9);
        checks++;
        if (bad_k !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bad_k_pulse: bad_k=%b valid=%b busy=%b, required 1 0 0", bad_k, out_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (bad_k !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bad_k_width: bad_k=%b valid=%b, required 0 0", bad_k, out_valid);
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] exp, held;
        logic       r;
        bit stalled = 0;
        bit done = 0;
        int n = 0;
        out_ready = 1'b0;
        exp = 8'h0F; held = '0;
        pulse_start(4'd4);
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp || out_idx !== 7'(n) ||
                $countones(out_data) != 4 || out_last !== (exp == 8'hF0)) begin
                failures++;
                $display("FAIL bp_word: valid=%b data=%h idx=%0d last=%b, required 1 %h %0d %b",
                         out_valid, out_data, out_idx, out_last, exp, n, exp == 8'hF0);
            end
            if (stalled) begin
                checks++;
                if (out_data !== held) begin
                    failures++;
                    $display("FAIL bp_stall_stable: data=%h, required %h", out_data, held);
                end
            end
            r = 1'($urandom_range(0, 1));
            out_ready = r;
            held = out_data;
            stalled = !r;
            @(negedge clk);
            if (r) begin
                if (exp == 8'hF0) done = 1;
                else begin
                    exp = next_w(exp, 4);
                    n++;
                end
            end
        end
        checks++;
        if (!done || n != 69 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_length: done=%0d last_idx=%0d busy=%b, required 1 69 0", done, n, busy);
        end
    endtask

    task automatic test_abort();
        logic [7:0] exp;
        int words = 0;
        out_ready = 1'b1;
        exp = 8'h03;
        pulse_start(4'd2);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_data !== exp || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL abort_prefix: data=%h valid=%b, required %h 1", out_data, out_valid, exp);
            end
            @(negedge clk);
            exp = next_w(exp, 2);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_drop: valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        abort = 1'b1; start = 1'b1; k = 4'd3;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || bad_k !== 1'b0) begin
            failures++;
            $display("FAIL abort_beats_start: valid=%b busy=%b bad_k=%b, required 0 0 0", out_valid, busy, bad_k);
        end
        pulse_start(4'd1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h01 || out_idx !== 7'd0) begin
            failures++;
            $display("FAIL restart_k1: valid=%b data=%h idx=%0d, required 1 01 0", out_valid, out_data, out_idx);
        end
        for (int cyc = 0; cyc < 50 && busy; cyc++) begin
            words++;
            @(negedge clk);
        end
        checks++;
        if (words != 8 || busy !== 1'b0) begin
            failures++;
            $display("FAIL restart_k1_len: words=%0d busy=%b, required 8 0", words, busy);
        end
    endtask

    task automatic test_restart_and_reset();
        logic [7:0] exp;
        int n = 0;
        bit done = 0;
        out_ready = 1'b1;
        exp = 8'h1F;
        pulse_start(4'd5);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp || out_idx !== 7'(n) || bad_k !== 1'b0) begin
                failures++;
                $display("FAIL busy_start_ignored: valid=%b data=%h idx=%0d bad_k=%b, required 1 %h %0d 0",
                         out_valid, out_data, out_idx, bad_k, exp, n);
            end
            start = (n == 3);
            k     = (n == 3) ? 4'd2 : 4'($urandom_range(0, 15));
            if (exp == 8'hF8) done = 1;
            else begin
                exp = next_w(exp, 5);
                n++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (!done || n != 55 || busy !== 1'b0) begin
            failures++;
            $display("FAIL k5_length: done=%0d last_idx=%0d busy=%b, required 1 55 0", done, n, busy);
        end
        out_ready = 1'b0;
        pulse_start(4'd6);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h3F) begin
            failures++;
            $display("FAIL pre_reset: valid=%b data=%h, required 1 3F", out_valid, out_data);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, bad_k, out_valid, out_last} !== 4'b0000 || out_data !== 8'h00 || out_idx !== 7'd0) begin
            failures++;
            $display("FAIL async_reset: busy=%b bad_k=%b valid=%b last=%b data=%h idx=%0d, required all zero",
                     busy, bad_k, out_valid, out_last, out_data, out_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

`ifdef PATGEN_SELFCHECK_EN
    task automatic test_selfcheck();
        out_ready = 1'b1;
        for (int kk = 0; kk <= 8; kk++) begin
            pulse_start(4'(kk));
            for (int cyc = 0; cyc < 200 && busy; cyc++) @(negedge clk);
            checks++;
            if (chk_err !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL selfcheck_sweep_k%0d: chk_err=%b busy=%b, required 0 0", kk, chk_err, busy);
            end
        end
        out_ready = 1'b0;
        pulse_start(4'd3);
        force dut.out_data = 8'h0F;
        out_ready = 1'b1;
        @(negedge clk);
        release dut.out_data;
        out_ready = 1'b0;
        checks++;
        if (chk_err !== 1'b1) begin
            failures++;
            $display("FAIL selfcheck_detect: chk_err=%b, required 1", chk_err);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_k3();
        test_single_words();
        test_back_pressure();
        test_abort();
        test_restart_and_reset();
`ifdef PATGEN_SELFCHECK_EN
        test_selfcheck();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
